sobel_frame_seq: RTL and testbench

Frame-level sequencer for the Sobel 3x3 convolution datapath on a 640x480 4-bit gray frame.
- Walks the frame column by column over interior rows.
- Fetches three vertically adjacent pixels per column from a shared single-port frame RAM, using a request/grant handshake.
- Presents each assembled column to the datapath window shifter.
- Issues edge-result write strobes with the centre-pixel address.
- Sits between the frame RAM arbiter and the convolution/edge-magnitude datapath.

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/sobel_addr_gen.sv | 68 ++++++
 rtl/sobel_frame_seq.sv | 179 +++++++++++++++++
 tb/tb_sobel_frame_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer: default geometry and the
// FSM / row-select encodings (the bench monitor also uses the state encoding).
package sobel_pkg;

  localparam int H_ACTIVE_DFLT = 640;
  localparam int V_ACTIVE_DFLT = 480;
  localparam int ADDR_W_DFLT   = 19;
  localparam int PIX_W_DFLT    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_TOP,
    ST_RD_MID,
    ST_RD_BOT,
    ST_COL,
    ST_ROW_END,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    ROW_TOP,
    ROW_MID,
    ROW_BOT
  } row_sel_t;

endpackage

// File: rtl/sobel_addr_gen.sv
// Address generator: three row-base registers stepped by H_ACTIVE plus the
// column counter, producing the RAM read address and the window-centre address.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int X_W      = $clog2(H_ACTIVE)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              next_col,
  input  logic              next_row,
  input  logic              rd_en,
  input  row_sel_t          row_sel,
  output logic [X_W-1:0]    x,
  output logic              last_col,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADDR_W-1:0] centre_addr
);

  localparam logic [ADDR_W-1:0] H_STEP  = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP2 = ADDR_W'(2 * H_ACTIVE);

  logic [ADDR_W-1:0] base_top;
  logic [ADDR_W-1:0] base_mid;
  logic [ADDR_W-1:0] base_bot;
  logic [ADDR_W-1:0] base_sel;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_top <= '0;
      base_mid <= H_STEP;
      base_bot <= H_STEP2;
      x        <= '0;
    end else if (load) begin
      base_top <= '0;
      base_mid <= H_STEP;
      base_bot <= H_STEP2;
      x        <= '0;
    end else if (next_row) begin
      base_top <= base_top + H_STEP;
      base_mid <= base_mid + H_STEP;
      base_bot <= base_bot + H_STEP;
      x        <= '0;
    end else if (next_col) begin
      x <= x + X_W'(1);
    end
  end

  always_comb begin
    base_sel = base_top;
    case (row_sel)
      ROW_MID: base_sel = base_mid;
      ROW_BOT: base_sel = base_bot;
      default: base_sel = base_top;
    endcase
  end

  // Address is forced to zero whenever no read is requested.
  assign ram_addr    = rd_en ? (base_sel + ADDR_W'(x)) : '0;
  assign centre_addr = base_mid + ADDR_W'(x) - ADDR_W'(1);
  assign last_col    = (x == X_W'(H_ACTIVE - 1));

endmodule

// File: rtl/sobel_frame_seq.sv
// Frame sequencer: fetches 3-pixel columns over interior rows, strobes them to
// the window shifter and issues edge-result writes for the window centre.
module sobel_frame_seq
  import sobel_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int V_ACTIVE = V_ACTIVE_DFLT,
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int PIX_W    = PIX_W_DFLT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  output logic               ram_read,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic               ram_gnt,
  input  logic [PIX_W-1:0]   ram_rdata,
  output logic               col_valid,
  output logic [3*PIX_W-1:0] col_data,
  output logic               edge_we,
  output logic [ADDR_W-1:0]  edge_addr,
  output logic               busy,
  output logic               done
);

  localparam int X_W = $clog2(H_ACTIVE);
  localparam int Y_W = $clog2(V_ACTIVE);

  state_t            state;
  state_t            next_state;
  logic [Y_W-1:0]    y;
  logic              load;
  logic              next_col;
  logic              next_row;
  logic              rd_en;
  logic              abort;
  logic              fin_done;
  row_sel_t          row_sel;
  logic [X_W-1:0]    x;
  logic              last_col;
  logic [ADDR_W-1:0] centre_addr;
  logic              cap_top;
  logic              cap_mid;
  logic [PIX_W-1:0]  top_q;
  logic [PIX_W-1:0]  mid_q;
  logic              s1_edge;
  logic [ADDR_W-1:0] s1_addr;

  sobel_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .ADDR_W   (ADDR_W),
    .X_W      (X_W)
  ) u_addr (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .next_col    (next_col),
    .next_row    (next_row),
    .rd_en       (rd_en),
    .row_sel     (row_sel),
    .x           (x),
    .last_col    (last_col),
    .ram_addr    (ram_addr),
    .centre_addr (centre_addr)
  );

  assign abort    = stop && (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign ram_read = rd_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    next_col   = 1'b0;
    next_row   = 1'b0;
    rd_en      = 1'b0;
    row_sel    = ROW_TOP;
    fin_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          load       = 1'b1;
          next_state = ST_RD_TOP;
        end
      end
      ST_RD_TOP: begin
        rd_en = 1'b1;
        if (ram_gnt) next_state = ST_RD_MID;
      end
      ST_RD_MID: begin
        rd_en   = 1'b1;
        row_sel = ROW_MID;
        if (ram_gnt) next_state = ST_RD_BOT;
      end
      ST_RD_BOT: begin
        rd_en   = 1'b1;
        row_sel = ROW_BOT;
        if (ram_gnt) next_state = ST_COL;
      end
      ST_COL: begin
        if (last_col) begin
          next_state = ST_ROW_END;
        end else begin
          next_col   = 1'b1;
          next_state = ST_RD_TOP;
        end
      end
      ST_ROW_END: begin
        if (y == Y_W'(V_ACTIVE - 2)) begin
          next_state = ST_FIN;
        end else begin
          next_row   = 1'b1;
          next_state = ST_RD_TOP;
        end
      end
      ST_FIN: begin
        // The last column strobe must drain into its edge write before done.
        if (!col_valid) begin
          fin_done   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (abort) begin
      next_state = ST_IDLE;
      next_col   = 1'b0;
      next_row   = 1'b0;
      fin_done   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y         <= Y_W'(1);
      cap_top   <= 1'b0;
      cap_mid   <= 1'b0;
      top_q     <= '0;
      mid_q     <= '0;
      col_valid <= 1'b0;
      col_data  <= '0;
      s1_edge   <= 1'b0;
      s1_addr   <= '0;
      edge_we   <= 1'b0;
      edge_addr <= '0;
      done      <= 1'b0;
    end else begin
      if (load)          y <= Y_W'(1);
      else if (next_row) y <= y + Y_W'(1);

      // Read data returns one cycle after its grant.
      cap_top <= (state == ST_RD_TOP) && ram_gnt;
      cap_mid <= (state == ST_RD_MID) && ram_gnt;
      if (cap_top) top_q <= ram_rdata;
      if (cap_mid) mid_q <= ram_rdata;

      col_valid <= (state == ST_COL) && !abort;
      if ((state == ST_COL) && !abort) begin
        col_data <= {top_q, mid_q, ram_rdata};
        s1_edge  <= (x >= X_W'(2));
        s1_addr  <= centre_addr;
      end

      edge_we <= col_valid && s1_edge && !abort;
      if (col_valid && s1_edge && !abort) edge_addr <= s1_addr;

      done <= fin_done;
    end
  end

endmodule

// File: tb/tb_sobel_frame_seq.sv
// Self-checking bench for sobel_frame_seq: an 8x5 frame through a table of
// grant/restart scenarios, plus stop, async reset and a 640-wide single row.
module tb_sobel_frame_seq;
  import sobel_pkg::*;

  localparam int TH = 8;
  localparam int TV = 5;
  localparam int WH = 640;
  localparam int WV = 3;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        ram_read;
  logic [18:0] ram_addr;
  logic        ram_gnt;
  logic [3:0]  ram_rdata;
  logic        col_valid;
  logic [11:0] col_data;
  logic        edge_we;
  logic [18:0] edge_addr;
  logic        busy;
  logic        done;

  logic        w_start;
  logic        w_read;
  logic [18:0] w_addr;
  logic        w_gnt;
  logic [3:0]  w_rdata;
  logic        w_col_valid;
  logic [11:0] w_col_data;
  logic        w_edge_we;
  logic [18:0] w_edge_addr;
  logic        w_busy;
  logic        w_done;

  sobel_frame_seq #(.H_ACTIVE(TH), .V_ACTIVE(TV)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .ram_read(ram_read), .ram_addr(ram_addr), .ram_gnt(ram_gnt),
    .ram_rdata(ram_rdata), .col_valid(col_valid), .col_data(col_data),
    .edge_we(edge_we), .edge_addr(edge_addr), .busy(busy), .done(done)
  );

  sobel_frame_seq #(.H_ACTIVE(WH), .V_ACTIVE(WV)) dut_w (
    .clock(clock), .reset_n(reset_n), .start(w_start), .stop(1'b0),
    .ram_read(w_read), .ram_addr(w_addr), .ram_gnt(w_gnt),
    .ram_rdata(w_rdata), .col_valid(w_col_valid), .col_data(w_col_data),
    .edge_we(w_edge_we), .edge_addr(w_edge_addr), .busy(w_busy), .done(w_done)
  );

  typedef struct {
    bit          rand_gnt;
    bit          restart;
    int          reads;
    int          cols;
    int          edges;
    int          first_edge;
    int          last_edge;
    int          dones;
    logic [11:0] first_col;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_gnt = 1'b0;

  // Monitor state for the 8x5 instance
  int          reads, cols, edges, dones, stalls, stab_err, range_err;
  logic [11:0] first_col;
  logic [18:0] addr_q[$];
  logic [18:0] edge_q[$];
  bit          prev_wait;
  logic [18:0] prev_addr;

  // Monitor state for the 640-wide instance
  int          w_reads, w_edges, w_dones;
  logic [18:0] w_last_addr, w_first_edge, w_last_edge;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial ram_gnt = 1'b1;
  always @(posedge clock) begin
    #1;
    ram_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  assign w_gnt = 1'b1;

  // RAM models: pix = addr % 16; ungranted cycles return a different value.
  always @(posedge clock) begin
    ram_rdata <= (ram_read && ram_gnt) ? ram_addr[3:0] : ~ram_addr[3:0];
    w_rdata   <= w_addr[3:0];
  end

  always @(negedge clock) begin
    if (ram_read && !ram_gnt) stalls++;
    if (prev_wait && (!ram_read || ram_addr != prev_addr)) stab_err++;
    prev_wait = ram_read && !ram_gnt;
    prev_addr = ram_addr;
    if (ram_read && ram_gnt) begin
      reads++;
      addr_q.push_back(ram_addr);
      if (ram_addr >= 19'(TH * TV)) range_err++;
    end
    if (col_valid) begin
      if (cols == 0) first_col = col_data;
      cols++;
    end
    if (edge_we) begin
      edges++;
      edge_q.push_back(edge_addr);
    end
    if (done) dones++;
    if (w_read && w_gnt) begin
      w_reads++;
      w_last_addr = w_addr;
    end
    if (w_edge_we) begin
      if (w_edges == 0) w_first_edge = w_edge_addr;
      w_last_edge = w_edge_addr;
      w_edges++;
    end
    if (w_done) w_dones++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    reads = 0; cols = 0; edges = 0; dones = 0; stalls = 0;
    stab_err = 0; range_err = 0; first_col = '0; prev_wait = 1'b0;
    addr_q.delete();
    edge_q.delete();
  endtask

  function automatic logic [54:0] out_vec();
    return {ram_read, ram_addr, col_valid, col_data, edge_we, edge_addr, busy, done};
  endfunction

  // Starts a frame and waits (bounded) for done, optionally re-pulsing start.
  task automatic run_frame(input bit restart);
    @(posedge clock); #2;
    clear_mon();
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    for (int c = 0; c < 3000 && dones == 0; c++) begin
      @(posedge clock); #2;
      start = (restart && c == 40);
    end
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
  endtask

  task automatic verify_frame(input string tag, input vec_t v);
    int k;
    int mism;
    check({tag, "_reads"}, reads, v.reads);
    check({tag, "_cols"}, cols, v.cols);
    check({tag, "_edges"}, edges, v.edges);
    check({tag, "_dones"}, dones, v.dones);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_first_col"}, first_col, v.first_col);
    check({tag, "_first_edge"}, (edge_q.size() > 0) ? edge_q[0] : 19'h7ffff, v.first_edge);
    check({tag, "_last_edge"}, (edge_q.size() > 0) ? edge_q[edge_q.size()-1] : 19'h7ffff, v.last_edge);
    check({tag, "_stable_wait"}, stab_err, 0);
    check({tag, "_addr_range"}, range_err, 0);
    k = 0; mism = 0;
    for (int yy = 1; yy <= TV - 2; yy++)
      for (int xx = 0; xx < TH; xx++)
        for (int r = 0; r < 3; r++) begin
          if (k >= addr_q.size() || addr_q[k] != 19'((yy - 1 + r) * TH + xx)) mism++;
          k++;
        end
    check({tag, "_addr_seq"}, mism, 0);
    k = 0; mism = 0;
    for (int yy = 1; yy <= TV - 2; yy++)
      for (int xx = 2; xx < TH; xx++) begin
        if (k >= edge_q.size() || edge_q[k] != 19'(yy * TH + xx - 1)) mism++;
        k++;
      end
    check({tag, "_edge_seq"}, mism, 0);
  endtask

  initial begin
    vec_t vecs[3];
    bit   found;

    // {rand_gnt, restart, reads, cols, edges, first_edge, last_edge, dones, first_col}
    vecs[0] = '{1'b0, 1'b0, 72, 24, 18, 9, 30, 1, 12'h080};
    vecs[1] = '{1'b1, 1'b0, 72, 24, 18, 9, 30, 1, 12'h080};
    vecs[2] = '{1'b0, 1'b1, 72, 24, 18, 9, 30, 1, 12'h080};

    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    w_start = 1'b0;
    clear_mon();
    w_reads = 0; w_edges = 0; w_dones = 0;
    repeat (3) @(posedge clock);
    #2;
    check("reset_outputs", out_vec(), 0);
    check("reset_x", dut.u_addr.x, 0);
    check("reset_y", dut.y, 1);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("idle_no_start_busy", busy, 0);

    for (int i = 0; i < 3; i++) begin
      rand_gnt = vecs[i].rand_gnt;
      run_frame(vecs[i].restart);
      verify_frame($sformatf("v%0d", i), vecs[i]);
      if (vecs[i].rand_gnt) check($sformatf("v%0d_stalls_seen", i), stalls > 0, 1);
    end
    rand_gnt = 1'b0;

    // stop together with start while idle: stop wins
    @(posedge clock); #2;
    start = 1'b1; stop = 1'b1;
    @(posedge clock); #2;
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", busy, 0);

    // stop during RD_MID of row 2
    @(posedge clock); #2;
    clear_mon();
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clock); #2;
      if (dut.state == ST_RD_MID && dut.y == 2) found = 1'b1;
    end
    check("stop_rd_mid_found", found, 1);
    stop = 1'b1;
    @(posedge clock); #2;
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_ram_read", ram_read, 0);
    cols = 0; edges = 0; dones = 0;
    repeat (20) @(posedge clock);
    #2;
    check("stop_no_cols", cols, 0);
    check("stop_no_edges", edges, 0);
    check("stop_no_done", dones, 0);
    run_frame(1'b0);
    verify_frame("after_stop", vecs[0]);

    // asynchronous reset between clock edges mid-frame
    @(posedge clock); #2;
    clear_mon();
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    repeat (30) @(posedge clock);
    #3;
    check("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 0);
    check("async_reset_state", dut.state, ST_IDLE);
    @(posedge clock); #2;
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #2;
    check("post_reset_idle", dut.state, ST_IDLE);
    check("post_reset_read", ram_read, 0);

    // 640-wide single interior row
    @(posedge clock); #2;
    w_reads = 0; w_edges = 0; w_dones = 0;
    w_start = 1'b1;
    @(posedge clock); #2;
    w_start = 1'b0;
    for (int c = 0; c < 4000 && w_dones == 0; c++) begin
      @(posedge clock); #2;
    end
    repeat (5) @(posedge clock);
    #2;
    check("wide_reads", w_reads, 3 * WH);
    check("wide_last_addr", w_last_addr, 3 * WH - 1);
    check("wide_edges", w_edges, WH - 2);
    check("wide_first_edge", w_first_edge, WH + 1);
    check("wide_last_edge", w_last_edge, WH + WH - 2);
    check("wide_dones", w_dones, 1);
    check("wide_busy_after", w_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
